acc_tile_sched: RTL and testbench
=================================

Name: acc_tile_sched

Overview:
- Tile-level sequencer between the kernel control block and the conv engine / AXI masters.
- On one start pulse it walks N output tiles. Per tile: request IFM and weight reads, start the engine, wait for end of conv, issue one AXI write of the tile's OFM, then advance.
- Reports busy/done back to kernel control so ap_done/ap_ready reflect the whole multi-tile job.

Parameters:
- ADDR_WIDTH, 64, width of AXI write address.
- TILE_W, 16, width of tile count/index.
- SIZE_WIDTH, 32, width of per-tile OFM byte count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- op_start  in  1  job start pulse from kernel control.
- cfg_num_tiles  in  TILE_W  tiles in job; sampled on op_start.
- cfg_ofm_base  in  ADDR_WIDTH  OFM base byte address; sampled on op_start.
- cfg_tile_bytes  in  SIZE_WIDTH  OFM bytes per tile; sampled on op_start.
- ifm_req_out  out  1  IFM read request pulse.
- ifm_done  in  1  IFM read complete pulse.
- wgt_req_out  out  1  weight read request pulse.
- wgt_done  in  1  weight read complete pulse.
- eng_start  out  1  conv engine start pulse.
- end_conv  in  1  engine finished pulse.
- wmst_req_out  out  1  write master request pulse.
- wmst_xfer_addr_out  out  ADDR_WIDTH  write address.
- wmst_xfer_size_out  out  64  write size in bytes (zero-extended).
- wmst_done  in  1  write complete pulse.
- tile_idx  out  TILE_W  current tile index.
- sched_busy  out  1  high from the cycle after an accepted op_start until FINISH exits.
- sched_done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: state IDLE; all outputs 0; done flags, tile_idx and latched config cleared. Reset mid-job aborts immediately. No pulse is emitted afterwards, and late done inputs are ignored.
- States:
  - IDLE: op_start at cycle T latches config. If cfg_num_tiles==0, go to FINISH (sched_done at T+1, no requests). Otherwise go to LOAD_REQ. op_start in any other state is ignored.
  - LOAD_REQ: ifm_req_out=1 and wgt_req_out=1 for exactly this cycle; clear ifm_got/wgt_got; go to LOAD_WAIT.
  - LOAD_WAIT: ifm_done sets ifm_got, wgt_done sets wgt_got (same-cycle arrival allowed, either order). Leave the cycle both are satisfied, counting that cycle's inputs, and go to ENG_START.
  - ENG_START: eng_start=1 for one cycle; go to ENG_WAIT.
  - ENG_WAIT: end_conv goes to WR_REQ.
  - WR_REQ: wmst_req_out=1 for one cycle; go to WR_WAIT.
  - WR_WAIT: on wmst_done, if tile_idx==num_tiles-1 go to FINISH. Otherwise tile_idx+1, addr+=tile_bytes, go to LOAD_REQ.
  - FINISH: sched_done=1 for one cycle; go to IDLE.
- wmst_xfer_addr_out = base + tile_idx*tile_bytes, computed by running accumulation, modulo 2^ADDR_WIDTH. It is valid and stable from WR_REQ through WR_WAIT and holds its value otherwise.
- wmst_xfer_size_out = latched tile_bytes, zero-extended.
- Done/end pulses arriving in a state that does not wait for them are dropped (no queuing).
- Latencies:
  - op_start→req pulses: 1 cycle.
  - last load done→eng_start: 1 cycle.
  - end_conv→wmst_req_out: 1 cycle.
  - wmst_done→next req pulses: 1 cycle.
  - final wmst_done→sched_done: 1 cycle.
- tile_idx returns to 0 on entering IDLE.

Optional Feature:
- Macro ACC_SCHED_WGT_REUSE_EN.
- Defined: weights load only for tile 0. For tiles ≥1, wgt_req_out stays 0, wgt_got is preset to 1 in LOAD_REQ, and LOAD_WAIT waits on ifm_done only.
- Undefined: weights are requested every tile, as described above.

Test Plan:
- num_tiles=3, base=0x1000, bytes=0x400, done inputs 2–5 cycles after each request → three wmst_req_out pulses with addr 0x1000/0x1400/0x1800 and size 0x400, 3 eng_start pulses, sched_done exactly 1 cycle after the 3rd wmst_done.
- op_start with num_tiles=0 → sched_done 1 cycle later, no req/eng_start pulses, sched_busy stays low except during FINISH.
- ifm_done and wgt_done in the same cycle, then wgt_done before ifm_done → eng_start 1 cycle after the later (or simultaneous) done in both cases.
- Second op_start during ENG_WAIT plus a spurious end_conv during LOAD_WAIT → both ignored, job completes normally with the original config.
- rst asserted during WR_WAIT, then wmst_done pulses → all outputs 0 next cycle, no sched_done, new op_start starts from tile 0.
- With ACC_SCHED_WGT_REUSE_EN, num_tiles=2 → one wgt_req_out pulse total, two ifm_req_out pulses, tile 1 eng_start follows ifm_done alone.

Source files
------------

// File: rtl/acc_tile_sched.sv
// acc_tile_sched
// ----------------------------------------------------------------------------
// Tile-level sequencer that sits between kernel control and the conv engine /
// AXI masters. A single op_start pulse launches a job of cfg_num_tiles tiles.
// Each tile goes through the same steps in order:
//   1. request the IFM and weight reads, then wait for both to complete
//   2. start the conv engine, then wait for end_conv
//   3. issue one AXI write of the tile's OFM, then wait for wmst_done
// After the last tile, a one-cycle sched_done pulse is emitted and the block
// returns to idle.
//
// Optional feature (compile-time macro ACC_SCHED_WGT_REUSE_EN):
//   When the macro is defined, weights are loaded for tile 0 only. For every
//   later tile, wgt_req_out stays low and the load phase waits on ifm_done
//   alone. When the macro is undefined, weights are requested for every tile.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   op_start            job start pulse (only accepted when idle)
//   cfg_num_tiles       number of tiles in the job       (sampled on op_start)
//   cfg_ofm_base        OFM base byte address            (sampled on op_start)
//   cfg_tile_bytes      OFM bytes written per tile       (sampled on op_start)
//   ifm_req_out         IFM read request pulse
//   ifm_done            IFM read complete pulse
//   wgt_req_out         weight read request pulse
//   wgt_done            weight read complete pulse
//   eng_start           conv engine start pulse
//   end_conv            conv engine finished pulse
//   wmst_req_out        write master request pulse
//   wmst_xfer_addr_out  write address; valid and stable from WR_REQ to WR_WAIT
//   wmst_xfer_size_out  write size in bytes, zero-extended to 64 bits
//   wmst_done           write complete pulse
//   tile_idx            index of the tile currently being processed
//   sched_busy          high while a job is in flight, FINISH included
//   sched_done          one-cycle pulse at job completion
// ----------------------------------------------------------------------------
module acc_tile_sched #(
  parameter int ADDR_WIDTH = 64,
  parameter int TILE_W     = 16,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_start,
  input  logic [TILE_W-1:0]     cfg_num_tiles,
  input  logic [ADDR_WIDTH-1:0] cfg_ofm_base,
  input  logic [SIZE_WIDTH-1:0] cfg_tile_bytes,
  output logic                  ifm_req_out,
  input  logic                  ifm_done,
  output logic                  wgt_req_out,
  input  logic                  wgt_done,
  output logic                  eng_start,
  input  logic                  end_conv,
  output logic                  wmst_req_out,
  output logic [ADDR_WIDTH-1:0] wmst_xfer_addr_out,
  output logic [63:0]           wmst_xfer_size_out,
  input  logic                  wmst_done,
  output logic [TILE_W-1:0]     tile_idx,
  output logic                  sched_busy,
  output logic                  sched_done
);

`ifdef ACC_SCHED_WGT_REUSE_EN
  localparam bit WGT_REUSE = 1'b1;
`else
  localparam bit WGT_REUSE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_ENG_START,
    S_ENG_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH
  } state_e;

  state_e                state_q,      state_d;
  logic [TILE_W-1:0]     num_tiles_q,  num_tiles_d;
  logic [SIZE_WIDTH-1:0] tile_bytes_q, tile_bytes_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;      // running base + idx*bytes
  logic [ADDR_WIDTH-1:0] wr_addr_q,    wr_addr_d;   // address presented to AXI
  logic [TILE_W-1:0]     tile_idx_q,   tile_idx_d;
  logic                  ifm_got_q,    ifm_got_d;
  logic                  wgt_got_q,    wgt_got_d;
  logic                  ifm_req_q,    ifm_req_d;
  logic                  wgt_req_q,    wgt_req_d;
  logic                  eng_start_q,  eng_start_d;
  logic                  wmst_req_q,   wmst_req_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;

  logic last_tile;
  assign last_tile = (tile_idx_q == (num_tiles_q - TILE_W'(1)));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    state_d      = state_q;
    num_tiles_d  = num_tiles_q;
    tile_bytes_d = tile_bytes_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    tile_idx_d   = tile_idx_q;
    ifm_got_d    = ifm_got_q;
    wgt_got_d    = wgt_got_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_start) begin
          num_tiles_d  = cfg_num_tiles;
          tile_bytes_d = cfg_tile_bytes;
          addr_d       = cfg_ofm_base;
          tile_idx_d   = '0;
          state_d      = (cfg_num_tiles == '0) ? S_FINISH : S_LOAD_REQ;
        end
      end

      S_LOAD_REQ: begin
        ifm_got_d = 1'b0;
        // Under weight reuse, tiles after the first already hold their weights.
        wgt_got_d = WGT_REUSE && (tile_idx_q != '0);
        state_d   = S_LOAD_WAIT;
      end

      S_LOAD_WAIT: begin
        // Include this cycle's done pulses, so the phase ends on the cycle the
        // last of them arrives rather than one cycle later.
        ifm_got_d = ifm_got_q | ifm_done;
        wgt_got_d = wgt_got_q | wgt_done;
        if (ifm_got_d && wgt_got_d) begin
          state_d = S_ENG_START;
        end
      end

      S_ENG_START: state_d = S_ENG_WAIT;

      S_ENG_WAIT: begin
        if (end_conv) begin
          state_d = S_WR_REQ;
        end
      end

      S_WR_REQ: state_d = S_WR_WAIT;

      S_WR_WAIT: begin
        if (wmst_done) begin
          if (last_tile) begin
            state_d = S_FINISH;
          end else begin
            tile_idx_d = tile_idx_q + TILE_W'(1);
            addr_d     = addr_q + ADDR_WIDTH'(tile_bytes_q);
            state_d    = S_LOAD_REQ;
          end
        end
      end

      S_FINISH: begin
        tile_idx_d = '0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // The write address is frozen on entry to WR_REQ. This keeps the AXI
    // address stable across the write, even though addr_q advances afterwards.
    if (state_d == S_WR_REQ) begin
      wr_addr_d = addr_q;
    end

    // Outputs are decoded from the next state, so that they leave a flop in
    // the same cycle the FSM enters the corresponding state.
    ifm_req_d   = (state_d == S_LOAD_REQ);
    wgt_req_d   = (state_d == S_LOAD_REQ) && (!WGT_REUSE || (tile_idx_d == '0));
    eng_start_d = (state_d == S_ENG_START);
    wmst_req_d  = (state_d == S_WR_REQ);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: every flop is assigned with <= so that all registers sample their
  // _d values from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_tiles_q  <= '0;
      tile_bytes_q <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      tile_idx_q   <= '0;
      ifm_got_q    <= 1'b0;
      wgt_got_q    <= 1'b0;
      ifm_req_q    <= 1'b0;
      wgt_req_q    <= 1'b0;
      eng_start_q  <= 1'b0;
      wmst_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_tiles_q  <= num_tiles_d;
      tile_bytes_q <= tile_bytes_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      tile_idx_q   <= tile_idx_d;
      ifm_got_q    <= ifm_got_d;
      wgt_got_q    <= wgt_got_d;
      ifm_req_q    <= ifm_req_d;
      wgt_req_q    <= wgt_req_d;
      eng_start_q  <= eng_start_d;
      wmst_req_q   <= wmst_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ifm_req_out        = ifm_req_q;
  assign wgt_req_out        = wgt_req_q;
  assign eng_start          = eng_start_q;
  assign wmst_req_out       = wmst_req_q;
  assign wmst_xfer_addr_out = wr_addr_q;
  assign wmst_xfer_size_out = 64'(tile_bytes_q);
  assign tile_idx           = tile_idx_q;
  assign sched_busy         = busy_q;
  assign sched_done         = done_q;

endmodule

// File: tb/tb_acc_tile_sched.sv
// Directed testbench for acc_tile_sched (default parameters).
// Inputs are driven 1 ns after each rising edge, and outputs are observed at
// that same point, which is well away from the active edge.
module tb_acc_tile_sched;

`ifdef ACC_SCHED_WGT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        op_start;
  logic [15:0] cfg_num_tiles;
  logic [63:0] cfg_ofm_base;
  logic [31:0] cfg_tile_bytes;
  logic        ifm_req_out, ifm_done;
  logic        wgt_req_out, wgt_done;
  logic        eng_start,   end_conv;
  logic        wmst_req_out;
  logic [63:0] wmst_xfer_addr_out;
  logic [63:0] wmst_xfer_size_out;
  logic        wmst_done;
  logic [15:0] tile_idx;
  logic        sched_busy, sched_done;

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse counters sampled on the falling edge; tests compare deltas.
  int c_ifm = 0, c_wgt = 0, c_eng = 0, c_wr = 0, c_done = 0;

  acc_tile_sched dut (
    .clk                (clk),
    .rst                (rst),
    .op_start           (op_start),
    .cfg_num_tiles      (cfg_num_tiles),
    .cfg_ofm_base       (cfg_ofm_base),
    .cfg_tile_bytes     (cfg_tile_bytes),
    .ifm_req_out        (ifm_req_out),
    .ifm_done           (ifm_done),
    .wgt_req_out        (wgt_req_out),
    .wgt_done           (wgt_done),
    .eng_start          (eng_start),
    .end_conv           (end_conv),
    .wmst_req_out       (wmst_req_out),
    .wmst_xfer_addr_out (wmst_xfer_addr_out),
    .wmst_xfer_size_out (wmst_xfer_size_out),
    .wmst_done          (wmst_done),
    .tile_idx           (tile_idx),
    .sched_busy         (sched_busy),
    .sched_done         (sched_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifm_req_out === 1'b1)  c_ifm++;
    if (wgt_req_out === 1'b1)  c_wgt++;
    if (eng_start === 1'b1)    c_eng++;
    if (wmst_req_out === 1'b1) c_wr++;
    if (sched_done === 1'b1)   c_done++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives op_start during the current cycle; returns in the following cycle.
  task automatic start_job(input logic [15:0] num, input logic [63:0] base,
                           input logic [31:0] bytes);
    op_start       = 1'b1;
    cfg_num_tiles  = num;
    cfg_ofm_base   = base;
    cfg_tile_bytes = bytes;
    tick();
    op_start = 1'b0;
  endtask

  // Entered in a tile's request cycle. Drives the done pulses after the given
  // delays (in cycles after the request) and checks the exact pulse timing.
  // Returns in the cycle right after the tile's wmst_done.
  task automatic drive_tile(input int idx, input int d_ifm, input int d_wgt,
                            input int d_eng, input int d_wr,
                            input logic [63:0] exp_addr, input logic [63:0] exp_size,
                            input bit last, input bit spur_end, input bit second_start);
    bit wgt_exp;
    int l;
    bit bad;
    wgt_exp = !REUSE || (idx == 0);
    l = (wgt_exp && d_wgt > d_ifm) ? d_wgt : d_ifm;

    n_chk++;
    if (ifm_req_out !== 1'b1 || wgt_req_out !== wgt_exp || tile_idx !== 16'(idx))
      $display("FAIL tile%0d_req: ifm_req=%0b wgt_req=%0b idx=%0d want 1 %0b %0d",
               idx, ifm_req_out, wgt_req_out, tile_idx, wgt_exp, idx);
    else n_pass++;

    bad = 1'b0;
    for (int k = 1; k <= l; k++) begin
      tick();
      if (eng_start !== 1'b0 || ifm_req_out !== 1'b0) bad = 1'b1;
      ifm_done = (k == d_ifm);
      wgt_done = (k == d_wgt);
      end_conv = spur_end && (k == 1);
    end
    tick();
    ifm_done = 1'b0;
    wgt_done = 1'b0;
    end_conv = 1'b0;
    n_chk++;
    if (bad || eng_start !== 1'b1)
      $display("FAIL tile%0d_eng_start: early=%0b eng_start=%0b want 0 1", idx, bad, eng_start);
    else n_pass++;

    bad = 1'b0;
    for (int j = 1; j <= d_eng; j++) begin
      tick();
      if (wmst_req_out !== 1'b0 || eng_start !== 1'b0) bad = 1'b1;
      end_conv = (j == d_eng);
      op_start = second_start && (j == 1);
      if (second_start && j == 1) begin
        cfg_num_tiles  = 16'd5;
        cfg_ofm_base   = 64'hDEAD_0000;
        cfg_tile_bytes = 32'h10;
      end
    end
    tick();
    end_conv = 1'b0;
    op_start = 1'b0;
    n_chk++;
    if (bad || wmst_req_out !== 1'b1 || wmst_xfer_addr_out !== exp_addr ||
        wmst_xfer_size_out !== exp_size)
      $display("FAIL tile%0d_wr_req: early=%0b req=%0b addr=%0h size=%0h want 0 1 %0h %0h",
               idx, bad, wmst_req_out, wmst_xfer_addr_out, wmst_xfer_size_out,
               exp_addr, exp_size);
    else n_pass++;

    bad = 1'b0;
    for (int j = 1; j <= d_wr; j++) begin
      tick();
      if (wmst_xfer_addr_out !== exp_addr || wmst_req_out !== 1'b0) bad = 1'b1;
      wmst_done = (j == d_wr);
    end
    tick();
    wmst_done = 1'b0;
    n_chk++;
    if (bad)
      $display("FAIL tile%0d_wr_wait: addr unstable or repeated req, addr=%0h want %0h",
               idx, wmst_xfer_addr_out, exp_addr);
    else n_pass++;

    n_chk++;
    if (last) begin
      if (sched_done !== 1'b1 || sched_busy !== 1'b1 || ifm_req_out !== 1'b0)
        $display("FAIL tile%0d_finish: done=%0b busy=%0b ifm_req=%0b want 1 1 0",
                 idx, sched_done, sched_busy, ifm_req_out);
      else n_pass++;
    end else begin
      if (ifm_req_out !== 1'b1 || tile_idx !== 16'(idx + 1) || wmst_xfer_addr_out !== exp_addr)
        $display("FAIL tile%0d_advance: ifm_req=%0b idx=%0d addr=%0h want 1 %0d %0h",
                 idx, ifm_req_out, tile_idx, wmst_xfer_addr_out, idx + 1, exp_addr);
      else n_pass++;
    end
  endtask

  // Called in the FINISH cycle; checks the return to idle one cycle later.
  task automatic check_idle_after(input string name);
    tick();
    n_chk++;
    if (sched_done !== 1'b0 || sched_busy !== 1'b0 || tile_idx !== 16'd0)
      $display("FAIL %s_idle: done=%0b busy=%0b idx=%0d want 0 0 0",
               name, sched_done, sched_busy, tile_idx);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_start = 1'b0; cfg_num_tiles = '0; cfg_ofm_base = '0; cfg_tile_bytes = '0;
    ifm_done = 1'b0; wgt_done = 1'b0; end_conv = 1'b0; wmst_done = 1'b0;
    tick(); tick();
    n_chk++;
    if ({ifm_req_out, wgt_req_out, eng_start, wmst_req_out, sched_busy, sched_done} !== 6'b0)
      $display("FAIL reset_pulses: got %b want 000000",
               {ifm_req_out, wgt_req_out, eng_start, wmst_req_out, sched_busy, sched_done});
    else n_pass++;
    n_chk++;
    if (wmst_xfer_addr_out !== 64'd0 || wmst_xfer_size_out !== 64'd0 || tile_idx !== 16'd0)
      $display("FAIL reset_values: addr=%0h size=%0h idx=%0d want 0 0 0",
               wmst_xfer_addr_out, wmst_xfer_size_out, tile_idx);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_three_tiles();
    int i0, w0, e0, r0, d0;
    i0 = c_ifm; w0 = c_wgt; e0 = c_eng; r0 = c_wr; d0 = c_done;
    start_job(16'd3, 64'h1000, 32'h400);
    drive_tile(0, 2, 3, 4, 2, 64'h1000, 64'h400, 1'b0, 1'b0, 1'b0);
    drive_tile(1, 5, 4, 2, 3, 64'h1400, 64'h400, 1'b0, 1'b0, 1'b0);
    drive_tile(2, 3, 5, 3, 5, 64'h1800, 64'h400, 1'b1, 1'b0, 1'b0);
    check_idle_after("three");
    n_chk++;
    if (c_ifm - i0 != 3 || c_wgt - w0 != (REUSE ? 1 : 3) || c_eng - e0 != 3 ||
        c_wr - r0 != 3 || c_done - d0 != 1)
      $display("FAIL three_counts: ifm=%0d wgt=%0d eng=%0d wr=%0d done=%0d want 3 %0d 3 3 1",
               c_ifm - i0, c_wgt - w0, c_eng - e0, c_wr - r0, c_done - d0, REUSE ? 1 : 3);
    else n_pass++;
  endtask

  task automatic test_zero_tiles();
    int i0, e0, r0, d0;
    i0 = c_ifm; e0 = c_eng; r0 = c_wr; d0 = c_done;
    n_chk++;
    if (sched_busy !== 1'b0)
      $display("FAIL zero_busy_pre: busy=%0b want 0", sched_busy);
    else n_pass++;
    start_job(16'd0, 64'h5000, 32'h40);
    n_chk++;
    if (sched_done !== 1'b1 || sched_busy !== 1'b1 || ifm_req_out !== 1'b0)
      $display("FAIL zero_done: done=%0b busy=%0b ifm_req=%0b want 1 1 0",
               sched_done, sched_busy, ifm_req_out);
    else n_pass++;
    check_idle_after("zero");
    tick(); tick();
    n_chk++;
    if (c_ifm != i0 || c_eng != e0 || c_wr != r0 || c_done - d0 != 1 || sched_busy !== 1'b0)
      $display("FAIL zero_counts: ifm=%0d eng=%0d wr=%0d done=%0d busy=%0b want 0 0 0 1 0",
               c_ifm - i0, c_eng - e0, c_wr - r0, c_done - d0, sched_busy);
    else n_pass++;
  endtask

  // Simultaneous loads on tile 0, weights before IFM on tile 1. The base is
  // chosen so that the second address wraps around to 0.
  task automatic test_load_order();
    start_job(16'd2, 64'hFFFF_FFFF_FFFF_FC00, 32'h400);
    drive_tile(0, 3, 3, 2, 2, 64'hFFFF_FFFF_FFFF_FC00, 64'h400, 1'b0, 1'b0, 1'b0);
    drive_tile(1, 4, 2, 2, 2, 64'h0, 64'h400, 1'b1, 1'b0, 1'b0);
    check_idle_after("order");
  endtask

  task automatic test_ignored_inputs();
    int i0, d0;
    i0 = c_ifm; d0 = c_done;
    start_job(16'd2, 64'h8000_0000, 32'h1000);
    drive_tile(0, 3, 2, 3, 2, 64'h8000_0000, 64'h1000, 1'b0, 1'b1, 1'b1);
    drive_tile(1, 2, 2, 2, 2, 64'h8000_1000, 64'h1000, 1'b1, 1'b0, 1'b0);
    check_idle_after("ignore");
    n_chk++;
    if (c_ifm - i0 != 2 || c_done - d0 != 1)
      $display("FAIL ignore_counts: ifm=%0d done=%0d want 2 1", c_ifm - i0, c_done - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int i0, e0, r0, d0;
    start_job(16'd3, 64'h2000, 32'h100);
    tick();                              // first LOAD_WAIT cycle
    ifm_done = 1'b1; wgt_done = 1'b1;
    tick();                              // ENG_START
    ifm_done = 1'b0; wgt_done = 1'b0;
    tick();                              // ENG_WAIT
    end_conv = 1'b1;
    tick();                              // WR_REQ
    end_conv = 1'b0;
    n_chk++;
    if (wmst_req_out !== 1'b1 || wmst_xfer_addr_out !== 64'h2000)
      $display("FAIL rstmid_wr_req: req=%0b addr=%0h want 1 2000", wmst_req_out, wmst_xfer_addr_out);
    else n_pass++;
    tick();                              // WR_WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({ifm_req_out, wgt_req_out, eng_start, wmst_req_out, sched_busy, sched_done} !== 6'b0 ||
        wmst_xfer_addr_out !== 64'd0 || wmst_xfer_size_out !== 64'd0 || tile_idx !== 16'd0)
      $display("FAIL rstmid_outputs: flags=%b addr=%0h size=%0h idx=%0d want 0 0 0 0",
               {ifm_req_out, wgt_req_out, eng_start, wmst_req_out, sched_busy, sched_done},
               wmst_xfer_addr_out, wmst_xfer_size_out, tile_idx);
    else n_pass++;
    i0 = c_ifm; e0 = c_eng; r0 = c_wr; d0 = c_done;
    wmst_done = 1'b1; ifm_done = 1'b1; wgt_done = 1'b1; end_conv = 1'b1;
    tick();
    wmst_done = 1'b0; ifm_done = 1'b0; wgt_done = 1'b0; end_conv = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_chk++;
    if (c_ifm != i0 || c_eng != e0 || c_wr != r0 || c_done != d0 || sched_busy !== 1'b0)
      $display("FAIL rstmid_quiet: ifm=%0d eng=%0d wr=%0d done=%0d busy=%0b want 0 0 0 0 0",
               c_ifm - i0, c_eng - e0, c_wr - r0, c_done - d0, sched_busy);
    else n_pass++;
    start_job(16'd1, 64'h3000, 32'h80);
    drive_tile(0, 2, 2, 2, 2, 64'h3000, 64'h80, 1'b1, 1'b0, 1'b0);
    check_idle_after("rstmid");
  endtask

`ifdef ACC_SCHED_WGT_REUSE_EN
  task automatic test_wgt_reuse();
    int i0, w0;
    i0 = c_ifm; w0 = c_wgt;
    start_job(16'd2, 64'h4000, 32'h200);
    drive_tile(0, 2, 3, 2, 2, 64'h4000, 64'h200, 1'b0, 1'b0, 1'b0);
    drive_tile(1, 2, 0, 2, 2, 64'h4200, 64'h200, 1'b1, 1'b0, 1'b0);
    check_idle_after("reuse");
    n_chk++;
    if (c_ifm - i0 != 2 || c_wgt - w0 != 1)
      $display("FAIL reuse_counts: ifm=%0d wgt=%0d want 2 1", c_ifm - i0, c_wgt - w0);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_three_tiles();
    test_zero_tiles();
    test_load_order();
    test_ignored_inputs();
    test_reset_mid_job();
`ifdef ACC_SCHED_WGT_REUSE_EN
    test_wgt_reuse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
